// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: fetch/decode/execute/writeback sequencing with
// programmable fetch/load wait states, mem_ready handshake, halt and illegal-opcode flag.
module multicycle_ctrl_fsm #(
  parameter int unsigned FETCH_WAIT = 1,
  parameter int unsigned LOAD_WAIT  = 1,
  parameter int unsigned PSR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opCode1,
  input  logic [3:0]       opCode2,
  input  logic [3:0]       conditionCode,
  input  logic [3:0]       shiftAmtIn,
  input  logic [PSR_W-1:0] PSR,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             storeReg,
  output logic             zeroExtend,
  output logic             SrcB,
  output logic             JmpEN,
  output logic             BranchEN,
  output logic             JALEN,
  output logic             PCEN,
  output logic             resultEN,
  output logic             immediateRegEN,
  output logic             updateAddress,
  output logic             wren_a,
  output logic             wren_b,
  output logic             nextInstruction,
  output logic             writeData,
  output logic             PSREN,
  output logic             regWriteEN,
  output logic             PCinstruction,
  output logic [3:0]       shifterControl,
  output logic [3:0]       ALUcontrol,
  output logic [3:0]       shiftAmtOut,
  output logic [1:0]       result,
  output logic             halted,
  output logic             illegal_op
);

  typedef enum logic [4:0] {
    StFetch, StFwait, StDecode, StMemAdr, StLbRd, StLbWait, StLbWr, StSbWr,
    StRtypeEx, StRtypeWr, StItypeEx, StItypeWr, StShiftEx, StShiftWr,
    StJalEx, StJalWr, StBcondEx, StJcondEx, StHalt
  } state_e;

  localparam int unsigned FetchInitInt = (FETCH_WAIT > 0) ? FETCH_WAIT - 1 : 0;
  localparam int unsigned LoadInitInt  = (LOAD_WAIT > 0) ? LOAD_WAIT - 1 : 0;
  localparam logic [3:0]  FetchInit    = 4'(FetchInitInt);
  localparam logic [3:0]  LoadInit     = 4'(LoadInitInt);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pass;

  // Only PSR[4:0] carries flags; upper bits are tied off here.
  logic unused_psr;
  assign unused_psr  = ^PSR;
  assign shiftAmtOut = shiftAmtIn;

  function automatic logic cond_pass(input logic [3:0] cc, input logic [4:0] p);
    unique case (cc)
      4'h0: cond_pass = p[4];
      4'h1: cond_pass = !p[4];
      4'h2: cond_pass = p[3];
      4'h3: cond_pass = !p[3];
      4'h4: cond_pass = p[0];
      4'h5: cond_pass = !p[0];
      4'h6: cond_pass = p[1];
      4'h7: cond_pass = !p[1];
      4'h8: cond_pass = p[2];
      4'h9: cond_pass = !p[2];
      4'hA: cond_pass = !p[4] && !p[0];
      4'hB: cond_pass = p[4] || p[0];
      4'hC: cond_pass = !p[1] && !p[4];
      4'hD: cond_pass = p[4] || p[1];
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign pass = cond_pass(conditionCode, PSR[4:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    storeReg        = 1'b0;
    zeroExtend      = 1'b1;
    SrcB            = 1'b1;
    JmpEN           = 1'b0;
    BranchEN        = 1'b0;
    JALEN           = 1'b0;
    PCEN            = 1'b0;
    resultEN        = 1'b0;
    immediateRegEN  = 1'b0;
    updateAddress   = 1'b1;
    wren_a          = 1'b0;
    wren_b          = 1'b0;
    nextInstruction = 1'b0;
    writeData       = 1'b1;
    PSREN           = 1'b0;
    regWriteEN      = 1'b0;
    PCinstruction   = 1'b0;
    shifterControl  = 4'h0;
    ALUcontrol      = 4'h5;
    result          = 2'd1;
    halted          = 1'b0;
    illegal_op      = 1'b0;

    unique case (state_q)
      StFetch: begin
        nextInstruction = 1'b1;
        PCinstruction   = 1'b1;
        PCEN            = 1'b1;
        if (FETCH_WAIT != 0) begin
          state_d    = StFwait;
          wait_cnt_d = FetchInit;
        end else begin
          state_d = StDecode;
        end
      end
      StFwait: begin
        nextInstruction = 1'b1;
        if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
        else if (mem_ready)     state_d    = StDecode;
      end
      StDecode: begin
        SrcB           = 1'b0;
        immediateRegEN = 1'b1;
        zeroExtend     = opCode2[3] && (opCode1 inside {4'h1, 4'h2, 4'h3, 4'hD});
        unique case (opCode1)
          4'h0:                                    state_d = StRtypeEx;
          4'h4:                                    state_d = StMemAdr;
          4'h8, 4'hF:                              state_d = StShiftEx;
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: state_d = StItypeEx;
          4'hC:                                    state_d = StBcondEx;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        unique case (opCode2)
          4'h0: state_d = StLbRd;
          4'h4: state_d = StSbWr;
          4'h8: state_d = StJalEx;
          4'hC: state_d = StJcondEx;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StLbRd: begin
        updateAddress = 1'b0;
        if (LOAD_WAIT != 0) begin
          state_d    = StLbWait;
          wait_cnt_d = LoadInit;
        end else begin
          state_d = StLbWr;
        end
      end
      StLbWait: begin
        updateAddress = 1'b0;
        if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
        else if (mem_ready)     state_d    = StLbWr;
      end
      StLbWr: begin
        writeData  = 1'b0;
        regWriteEN = 1'b1;
        state_d    = halt ? StHalt : StFetch;
      end
      StSbWr: begin
        storeReg      = 1'b1;
        updateAddress = 1'b0;
        wren_a        = 1'b1;
        state_d       = halt ? StHalt : StFetch;
      end
      StRtypeEx: begin
        ALUcontrol = opCode2;
        PSREN      = 1'b1;
        resultEN   = 1'b1;
        state_d    = StRtypeWr;
      end
      StRtypeWr: begin
        regWriteEN = !(opCode2 inside {4'h0, 4'hB});
        state_d    = halt ? StHalt : StFetch;
      end
      StItypeEx: begin
        ALUcontrol = opCode1;
        SrcB       = 1'b0;
        PSREN      = 1'b1;
        resultEN   = 1'b1;
        state_d    = StItypeWr;
      end
      StItypeWr: begin
        regWriteEN = (opCode1 != 4'hB);
        state_d    = halt ? StHalt : StFetch;
      end
      StShiftEx: begin
        shifterControl = (opCode1 == 4'hF) ? 4'hF : opCode2;
        SrcB           = (opCode1 != 4'hF) && (opCode2 == 4'h4);
        result         = 2'd0;
        resultEN       = 1'b1;
        state_d        = StShiftWr;
      end
      StShiftWr, StJalWr: begin
        regWriteEN = 1'b1;
        state_d    = halt ? StHalt : StFetch;
      end
      StJalEx: begin
        JALEN         = 1'b1;
        PCinstruction = 1'b1;
        resultEN      = 1'b1;
        PCEN          = 1'b1;
        result        = 2'd3;
        state_d       = StJalWr;
      end
      StBcondEx: begin
        BranchEN      = pass;
        PCinstruction = 1'b1;
        SrcB          = 1'b0;
        PCEN          = 1'b1;
        state_d       = halt ? StHalt : StFetch;
      end
      StJcondEx: begin
        JmpEN         = pass;
        PCinstruction = 1'b1;
        PCEN          = 1'b1;
        state_d       = halt ? StHalt : StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (!halt) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Outputs sit at their idle values for as long as reset is held.
    if (!reset) begin
      storeReg        = 1'b0;
      zeroExtend      = 1'b1;
      SrcB            = 1'b1;
      JmpEN           = 1'b0;
      BranchEN        = 1'b0;
      JALEN           = 1'b0;
      PCEN            = 1'b0;
      resultEN        = 1'b0;
      immediateRegEN  = 1'b0;
      updateAddress   = 1'b1;
      wren_a          = 1'b0;
      wren_b          = 1'b0;
      nextInstruction = 1'b0;
      writeData       = 1'b1;
      PSREN           = 1'b0;
      regWriteEN      = 1'b0;
      PCinstruction   = 1'b0;
      shifterControl  = 4'h0;
      ALUcontrol      = 4'h5;
      result          = 2'd1;
      halted          = 1'b0;
      illegal_op      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (FETCH_WAIT=2, LOAD_WAIT=1).
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opCode1, opCode2, conditionCode, shiftAmtIn;
  logic [7:0] PSR;
  logic       mem_ready, halt;
  logic storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN, resultEN, immediateRegEN;
  logic updateAddress, wren_a, wren_b, nextInstruction, writeData, PSREN, regWriteEN;
  logic PCinstruction, halted, illegal_op;
  logic [3:0] shifterControl, ALUcontrol, shiftAmtOut;
  logic [1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.FETCH_WAIT(2), .LOAD_WAIT(1), .PSR_W(8)) dut (
    .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2),
    .conditionCode(conditionCode), .shiftAmtIn(shiftAmtIn), .PSR(PSR),
    .mem_ready(mem_ready), .halt(halt), .storeReg(storeReg), .zeroExtend(zeroExtend),
    .SrcB(SrcB), .JmpEN(JmpEN), .BranchEN(BranchEN), .JALEN(JALEN), .PCEN(PCEN),
    .resultEN(resultEN), .immediateRegEN(immediateRegEN), .updateAddress(updateAddress),
    .wren_a(wren_a), .wren_b(wren_b), .nextInstruction(nextInstruction),
    .writeData(writeData), .PSREN(PSREN), .regWriteEN(regWriteEN),
    .PCinstruction(PCinstruction), .shifterControl(shifterControl),
    .ALUcontrol(ALUcontrol), .shiftAmtOut(shiftAmtOut), .result(result),
    .halted(halted), .illegal_op(illegal_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH -> FWAIT -> FWAIT -> DECODE with mem_ready high.
  task automatic to_decode();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; opCode1 = 4'h5; opCode2 = 4'h0; conditionCode = 4'h0;
    shiftAmtIn = 4'hA; PSR = 8'h00; mem_ready = 1'b1; halt = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if (PCEN !== 1'b0) begin bad++; $display("FAIL rst_pcen got=%b want=0", PCEN); end
    total++;
    if ({zeroExtend, SrcB, updateAddress, writeData, nextInstruction, regWriteEN} !== 6'b111100) begin
      bad++; $display("FAIL rst_strobes got=%b want=111100",
                      {zeroExtend, SrcB, updateAddress, writeData, nextInstruction, regWriteEN});
    end
    total++;
    if ({ALUcontrol, result, halted, illegal_op} !== 8'b0101_01_0_0) begin
      bad++; $display("FAIL rst_alu_res got=%b want=01010100", {ALUcontrol, result, halted, illegal_op});
    end
    total++; if (shiftAmtOut !== 4'hA) begin bad++; $display("FAIL shamt got=%h want=a", shiftAmtOut); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({PCEN, PCinstruction, nextInstruction} !== 3'b111) begin
      bad++; $display("FAIL rst_release_fetch got=%b want=111", {PCEN, PCinstruction, nextInstruction});
    end
  endtask

  task automatic test_addi();
    opCode1 = 4'h5; opCode2 = 4'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({nextInstruction, PCEN, immediateRegEN} !== 3'b100) begin
        bad++; $display("FAIL addi_fwait%0d got=%b want=100", i, {nextInstruction, PCEN, immediateRegEN});
      end
    end
    tick();
    total++;
    if ({immediateRegEN, SrcB, nextInstruction} !== 3'b100) begin
      bad++; $display("FAIL addi_decode got=%b want=100", {immediateRegEN, SrcB, nextInstruction});
    end
    tick();
    total++;
    if ({ALUcontrol, PSREN, resultEN, SrcB} !== 7'b0101_1_1_0) begin
      bad++; $display("FAIL addi_ex got=%b want=0101110", {ALUcontrol, PSREN, resultEN, SrcB});
    end
    tick();
    total++; if (regWriteEN !== 1'b1) begin bad++; $display("FAIL addi_wr got=%b want=1", regWriteEN); end
    tick();
    total++; if (PCEN !== 1'b1) begin bad++; $display("FAIL addi_refetch got=%b want=1", PCEN); end
  endtask

  task automatic test_halt();
    opCode1 = 4'h0; opCode2 = 4'h3;
    to_decode();
    tick();
    total++;
    if ({ALUcontrol, PSREN, resultEN} !== 6'b0011_1_1) begin
      bad++; $display("FAIL rtype_ex got=%b want=001111", {ALUcontrol, PSREN, resultEN});
    end
    halt = 1'b1;
    tick();
    total++;
    if ({regWriteEN, halted} !== 2'b10) begin
      bad++; $display("FAIL rtype_wr got=%b want=10", {regWriteEN, halted});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({halted, PCEN, regWriteEN} !== 3'b100) begin
        bad++; $display("FAIL halt_hold%0d got=%b want=100", i, {halted, PCEN, regWriteEN});
      end
    end
    halt = 1'b0;
    tick();
    total++;
    if ({halted, PCEN} !== 2'b01) begin
      bad++; $display("FAIL halt_resume got=%b want=01", {halted, PCEN});
    end
  endtask

  task automatic test_load();
    opCode1 = 4'h4; opCode2 = 4'h0;
    to_decode();
    tick();
    total++;
    if ({immediateRegEN, updateAddress, PCEN, illegal_op} !== 4'b0100) begin
      bad++; $display("FAIL lb_memadr got=%b want=0100", {immediateRegEN, updateAddress, PCEN, illegal_op});
    end
    tick();
    total++; if (updateAddress !== 1'b0) begin bad++; $display("FAIL lb_rd got=%b want=0", updateAddress); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({updateAddress, writeData, regWriteEN} !== 3'b010) begin
        bad++; $display("FAIL lb_wait%0d got=%b want=010", i, {updateAddress, writeData, regWriteEN});
      end
      tick();
    end
    total++;
    if ({updateAddress, writeData} !== 2'b01) begin
      bad++; $display("FAIL lb_wait_last got=%b want=01", {updateAddress, writeData});
    end
    mem_ready = 1'b1;
    tick();
    total++;
    if ({writeData, regWriteEN} !== 2'b01) begin
      bad++; $display("FAIL lb_wr got=%b want=01", {writeData, regWriteEN});
    end
    tick();
    total++; if (PCEN !== 1'b1) begin bad++; $display("FAIL lb_refetch got=%b want=1", PCEN); end
  endtask

  task automatic test_bcond();
    logic [7:0] psr_v [2] = '{8'h10, 8'h00};
    logic       exp_b [2] = '{1'b1, 1'b0};
    opCode1 = 4'hC; conditionCode = 4'h0;
    for (int i = 0; i < 2; i++) begin
      PSR = psr_v[i];
      to_decode();
      tick();
      total++;
      if ({BranchEN, PCEN, PCinstruction, SrcB} !== {exp_b[i], 3'b110}) begin
        bad++; $display("FAIL bcond%0d got=%b want=%b", i,
                        {BranchEN, PCEN, PCinstruction, SrcB}, {exp_b[i], 3'b110});
      end
      tick();
    end
  endtask

  task automatic test_jump();
    logic [7:0] psr_v [2] = '{8'h00, 8'h01};
    logic       exp_j [2] = '{1'b1, 1'b0};
    opCode1 = 4'h4; opCode2 = 4'hC; conditionCode = 4'hA;
    for (int i = 0; i < 2; i++) begin
      PSR = psr_v[i];
      to_decode();
      repeat (2) tick();
      total++;
      if ({JmpEN, PCEN, PCinstruction} !== {exp_j[i], 2'b11}) begin
        bad++; $display("FAIL jcond%0d got=%b want=%b", i, {JmpEN, PCEN, PCinstruction}, {exp_j[i], 2'b11});
      end
      tick();
    end
    opCode2 = 4'h8;
    to_decode();
    repeat (2) tick();
    total++;
    if ({JALEN, PCEN, resultEN, result} !== 5'b111_11) begin
      bad++; $display("FAIL jal_ex got=%b want=11111", {JALEN, PCEN, resultEN, result});
    end
    tick();
    total++;
    if ({regWriteEN, JALEN} !== 2'b10) begin
      bad++; $display("FAIL jal_wr got=%b want=10", {regWriteEN, JALEN});
    end
    tick();
  endtask

  task automatic test_shift();
    opCode1 = 4'h8; opCode2 = 4'h4;
    to_decode();
    tick();
    total++;
    if ({shifterControl, SrcB, result, resultEN} !== 8'b0100_1_00_1) begin
      bad++; $display("FAIL shift_ex got=%b want=01001001", {shifterControl, SrcB, result, resultEN});
    end
    tick();
    total++; if (regWriteEN !== 1'b1) begin bad++; $display("FAIL shift_wr got=%b want=1", regWriteEN); end
    tick();
  endtask

  task automatic test_illegal();
    opCode1 = 4'h6; opCode2 = 4'h0;
    to_decode();
    total++;
    if ({illegal_op, immediateRegEN} !== 2'b11) begin
      bad++; $display("FAIL illegal_decode got=%b want=11", {illegal_op, immediateRegEN});
    end
    tick();
    total++;
    if ({illegal_op, PCEN, regWriteEN} !== 3'b010) begin
      bad++; $display("FAIL illegal_next got=%b want=010", {illegal_op, PCEN, regWriteEN});
    end
  endtask

  task automatic test_reset_mid_wait();
    opCode1 = 4'h4; opCode2 = 4'h0;
    to_decode();
    repeat (2) tick();
    mem_ready = 1'b0;
    repeat (2) tick();
    total++; if (updateAddress !== 1'b0) begin bad++; $display("FAIL rmw_inwait got=%b want=0", updateAddress); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({PCEN, updateAddress} !== 2'b01) begin
      bad++; $display("FAIL rmw_during got=%b want=01", {PCEN, updateAddress});
    end
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (PCEN !== 1'b1) begin bad++; $display("FAIL rmw_release got=%b want=1", PCEN); end
    tick();
    total++;
    if ({nextInstruction, PCEN} !== 2'b10) begin
      bad++; $display("FAIL rmw_fwait got=%b want=10", {nextInstruction, PCEN});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_halt();
    test_load();
    test_bcond();
    test_jump();
    test_shift();
    test_illegal();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
